dffram_bist: RTL and testbench

March C- built-in self-test engine that acts as the initiator for a single DFFRAM macro port (CLK/EN/WE[3:0]/Di/Do/A, 256*COLS words of 32 bits). It generates addresses, write data and byte enables, checks read data, and reports pass or fail with failure capture. It sits beside each DFFRAM instance. The integration mux hands the RAM port to this block while busy=1.

---
 rtl/dffram_bist.sv | 215 +++++++++++++++++++++
 tb/tb_dffram_bist.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/dffram_bist.sv
// March C- BIST initiator for one DFFRAM port; 256*COLS words of 32 bits.
// Optional second pass with checkerboard backgrounds when BIST_CHECKERBOARD_EN is defined.
module dffram_bist #(
  parameter int unsigned COLS = 1,
  localparam int unsigned AW = 8 + $clog2(COLS)
) (
  input  logic          CLK,
  input  logic          RESETn,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW-1:0] fail_addr,
  output logic [31:0]   fail_data,
  output logic [31:0]   fail_exp,
  output logic          ram_EN,
  output logic [3:0]    ram_WE,
  output logic [AW-1:0] ram_A,
  output logic [31:0]   ram_Di,
  input  logic [31:0]   ram_Do
);

  localparam int unsigned N = 256 * COLS;
  localparam logic [AW-1:0] LastAddr = AW'(N - 1);
  localparam logic [AW-1:0] One = AW'(1);

  typedef enum logic [3:0] {
    StIdle, StM0, StM1, StM2, StM3, StM4, StM5, StFlush, StDone
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          phase_q, phase_d;      // 0: read cycle, 1: write+compare cycle
  logic          cmp_valid_q, cmp_valid_d;
  logic [AW-1:0] cmp_addr_q, cmp_addr_d;
  logic          pass_q, pass_d;
  logic [AW-1:0] fail_addr_q, fail_addr_d;
  logic [31:0]   fail_data_q, fail_data_d;
  logic [31:0]   fail_exp_q, fail_exp_d;
  logic [31:0]   bg0, bg1;

`ifdef BIST_CHECKERBOARD_EN
  logic bg_q, bg_d;
  assign bg0 = bg_q ? 32'h5555_5555 : 32'h0000_0000;
  assign bg1 = bg_q ? 32'hAAAA_AAAA : 32'hFFFF_FFFF;
`else
  assign bg0 = 32'h0000_0000;
  assign bg1 = 32'hFFFF_FFFF;
`endif

  logic          do_cmp;
  logic [31:0]   exp_data;
  logic [AW-1:0] cmp_a;
  logic          desc, first_bg;
  state_e        next_march;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    phase_d     = phase_q;
    cmp_valid_d = 1'b0;
    cmp_addr_d  = cmp_addr_q;
    pass_d      = pass_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    fail_exp_d  = fail_exp_q;
`ifdef BIST_CHECKERBOARD_EN
    bg_d        = bg_q;
`endif
    ram_EN      = 1'b0;
    ram_WE      = 4'h0;
    ram_A       = '0;
    ram_Di      = 32'h0;
    do_cmp      = 1'b0;
    exp_data    = bg0;
    cmp_a       = addr_q;
    desc        = (state_q == StM3) || (state_q == StM4);
    first_bg    = (state_q == StM1) || (state_q == StM3);
    next_march  = StM5;

    unique case (state_q)
      StM1:    next_march = StM2;
      StM2:    next_march = StM3;
      StM3:    next_march = StM4;
      default: next_march = StM5;
    endcase

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d     = StM0;
          addr_d      = '0;
          phase_d     = 1'b0;
          pass_d      = 1'b0;
          fail_addr_d = '0;
          fail_data_d = 32'h0;
          fail_exp_d  = 32'h0;
`ifdef BIST_CHECKERBOARD_EN
          bg_d        = 1'b0;
`endif
        end
      end
      StM0: begin
        ram_EN = 1'b1;
        ram_WE = 4'hF;
        ram_A  = addr_q;
        ram_Di = bg0;
        if (addr_q == LastAddr) begin
          addr_d  = '0;
          state_d = StM1;
        end else begin
          addr_d = addr_q + One;
        end
      end
      StM1, StM2, StM3, StM4: begin
        ram_EN = 1'b1;
        ram_A  = addr_q;
        if (phase_q) begin
          ram_WE   = 4'hF;
          ram_Di   = first_bg ? bg1 : bg0;
          exp_data = first_bg ? bg0 : bg1;
          do_cmp   = 1'b1;
          phase_d  = 1'b0;
          if (addr_q == (desc ? '0 : LastAddr)) begin
            state_d = next_march;
            // M3/M4 run descending and start from the top address.
            addr_d  = (state_q == StM2 || state_q == StM3) ? LastAddr : '0;
          end else begin
            addr_d = desc ? addr_q - One : addr_q + One;
          end
        end else begin
          phase_d = 1'b1;
        end
      end
      StM5: begin
        ram_EN      = 1'b1;
        ram_A       = addr_q;
        do_cmp      = cmp_valid_q;
        cmp_a       = cmp_addr_q;
        cmp_valid_d = 1'b1;
        cmp_addr_d  = addr_q;
        if (addr_q == LastAddr) begin
          state_d = StFlush;
        end else begin
          addr_d = addr_q + One;
        end
      end
      StFlush: begin
        do_cmp = 1'b1;
        cmp_a  = cmp_addr_q;
`ifdef BIST_CHECKERBOARD_EN
        if (!bg_q) begin
          state_d = StM0;
          addr_d  = '0;
          bg_d    = 1'b1;
        end else begin
          state_d = StDone;
          pass_d  = 1'b1;
        end
`else
        state_d = StDone;
        pass_d  = 1'b1;
`endif
      end
      default: state_d = StIdle;
    endcase

    // First mismatch wins: capture and abort on the next edge.
    if (do_cmp && (ram_Do != exp_data)) begin
      fail_addr_d = cmp_a;
      fail_data_d = ram_Do;
      fail_exp_d  = exp_data;
      pass_d      = 1'b0;
      state_d     = StDone;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      phase_q     <= 1'b0;
      cmp_valid_q <= 1'b0;
      cmp_addr_q  <= '0;
      pass_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= 32'h0;
      fail_exp_q  <= 32'h0;
`ifdef BIST_CHECKERBOARD_EN
      bg_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      phase_q     <= phase_d;
      cmp_valid_q <= cmp_valid_d;
      cmp_addr_q  <= cmp_addr_d;
      pass_q      <= pass_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
      fail_exp_q  <= fail_exp_d;
`ifdef BIST_CHECKERBOARD_EN
      bg_q        <= bg_d;
`endif
    end
  end

  assign busy      = (state_q != StIdle) && (state_q != StDone);
  assign done      = (state_q == StDone);
  assign pass      = pass_q;
  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;
  assign fail_exp  = fail_exp_q;

endmodule

// File: tb/tb_dffram_bist.sv
// Bench for dffram_bist: COLS=1 and COLS=2 instances, each with a behavioural RAM
// carrying injectable stuck-at and bit-short faults; results checked via a scoreboard.
module tb_dffram_bist;

`ifdef BIST_CHECKERBOARD_EN
  localparam int FullBusy = 5122;
`else
  localparam int FullBusy = 2561;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start1 = 1'b0;
  logic start2 = 1'b0;
  always #5 clk = ~clk;

  logic        b1_busy, b1_done, b1_pass, r1_en;
  logic [7:0]  b1_faddr, r1_a;
  logic [31:0] b1_fdata, b1_fexp, r1_di, do1;
  logic [3:0]  r1_we;
  logic        b2_busy, b2_done, b2_pass, r2_en;
  logic [8:0]  b2_faddr, r2_a;
  logic [31:0] b2_fdata, b2_fexp, r2_di, do2;
  logic [3:0]  r2_we;

  dffram_bist #(.COLS(1)) u1 (
    .CLK(clk), .RESETn(rstn), .start(start1), .busy(b1_busy), .done(b1_done),
    .pass(b1_pass), .fail_addr(b1_faddr), .fail_data(b1_fdata), .fail_exp(b1_fexp),
    .ram_EN(r1_en), .ram_WE(r1_we), .ram_A(r1_a), .ram_Di(r1_di), .ram_Do(do1)
  );

  dffram_bist #(.COLS(2)) u2 (
    .CLK(clk), .RESETn(rstn), .start(start2), .busy(b2_busy), .done(b2_done),
    .pass(b2_pass), .fail_addr(b2_faddr), .fail_data(b2_fdata), .fail_exp(b2_fexp),
    .ram_EN(r2_en), .ram_WE(r2_we), .ram_A(r2_a), .ram_Di(r2_di), .ram_Do(do2)
  );

  // Fault set per RAM: one faulty word, stuck-at masks and a wired-AND short of bits 1:0.
  logic [31:0] mem1 [256];
  logic [31:0] mem2 [512];
  logic [8:0]  f1_addr = '0, f2_addr = '0;
  logic [31:0] f1_s1 = '0, f1_s0 = '0, f2_s1 = '0, f2_s0 = '0;
  bit          f1_sh = 1'b0;

  function automatic logic [31:0] faulty(input logic [31:0] d, input logic [31:0] s1,
                                         input logic [31:0] s0, input bit sh);
    logic [31:0] r;
    r = (d | s1) & ~s0;
    if (sh) r[1:0] = {2{r[1] & r[0]}};
    return r;
  endfunction

  always @(posedge clk) begin
    if (r1_en) begin
      do1 <= ({1'b0, r1_a} == f1_addr) ? faulty(mem1[r1_a], f1_s1, f1_s0, f1_sh) : mem1[r1_a];
      if (r1_we == 4'hF) mem1[r1_a] <= r1_di;
    end else begin
      do1 <= 32'h0;
    end
  end

  always @(posedge clk) begin
    if (r2_en) begin
      do2 <= (r2_a == f2_addr) ? faulty(mem2[r2_a], f2_s1, f2_s0, 1'b0) : mem2[r2_a];
      if (r2_we == 4'hF) mem2[r2_a] <= r2_di;
    end else begin
      do2 <= 32'h0;
    end
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, want);
    end
  endtask

  typedef struct {
    string       name;
    bit          pass;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
    int          cycles;
  } exp_t;
  exp_t sb[$];

  task automatic expect_result(input string name, input bit p, input logic [31:0] a,
                               input logic [31:0] d, input logic [31:0] e, input int c);
    exp_t x;
    x.name = name; x.pass = p; x.addr = a; x.data = d; x.exp = e; x.cycles = c;
    sb.push_back(x);
  endtask

  task automatic score(input int which, input int cycles);
    exp_t x;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    x = sb.pop_front();
    check({x.name, "_cycles"}, cycles, x.cycles);
    check({x.name, "_done"}, 32'(which == 1 ? b1_done : b2_done), 32'd1);
    check({x.name, "_pass"}, 32'(which == 1 ? b1_pass : b2_pass), 32'(x.pass));
    check({x.name, "_faddr"}, which == 1 ? 32'(b1_faddr) : 32'(b2_faddr), x.addr);
    check({x.name, "_fdata"}, which == 1 ? b1_fdata : b2_fdata, x.data);
    check({x.name, "_fexp"}, which == 1 ? b1_fexp : b2_fexp, x.exp);
    check({x.name, "_en_idle"}, 32'(which == 1 ? r1_en : r2_en), 32'd0);
  endtask

  // Pulse start, then count busy cycles until done; optional mid-run events keyed on
  // the busy count. Returns aborted=1 if a reset was applied.
  task automatic run(input int which, input int inject_at, input int restart_at,
                     input int reset_at, output int n, output bit aborted);
    bit fin = 1'b0;
    n = 0;
    aborted = 1'b0;
    if (which == 1) start1 = 1'b1; else start2 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; start2 = 1'b0;
    for (int i = 0; i < 30000 && !fin && !aborted; i++) begin
      if (which == 1 ? b1_done : b2_done) begin
        fin = 1'b1;
      end else begin
        if (which == 1 ? b1_busy : b2_busy) n++;
        if (n == inject_at) f2_s1 = 32'h0000_0001;
        if (which == 2) start2 = (n == restart_at);
        if (n == reset_at) rstn = 1'b0;
        @(posedge clk); #1;
        start2 = 1'b0;
        if (!rstn) begin
          rstn = 1'b1;
          aborted = 1'b1;
        end
      end
    end
    if (!fin && !aborted) check("timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, 32'(b1_busy), 32'd0);
    check({tag, "_done"}, 32'(b1_done), 32'd0);
    check({tag, "_pass"}, 32'(b1_pass), 32'd0);
    check({tag, "_faddr"}, 32'(b1_faddr), 32'd0);
    check({tag, "_fdata"}, b1_fdata, 32'd0);
    check({tag, "_fexp"}, b1_fexp, 32'd0);
    check({tag, "_en"}, 32'(r1_en), 32'd0);
    check({tag, "_we"}, 32'(r1_we), 32'd0);
    check({tag, "_a"}, 32'(r1_a), 32'd0);
    check({tag, "_di"}, r1_di, 32'd0);
  endtask

  initial begin
    int  n;
    bit  ab;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    check("reset_u2_busy", 32'(b2_busy), 32'd0);
    check("reset_u2_en", 32'(r2_en), 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Fault-free solid run; done must hold afterwards.
    expect_result("clean", 1'b1, 32'h0, 32'h0, 32'h0, FullBusy);
    run(1, -1, -1, -1, n, ab);
    score(1, n);
    repeat (5) @(posedge clk);
    #1;
    check("clean_done_hold", 32'(b1_done), 32'd1);
    check("clean_busy_low", 32'(b1_busy), 32'd0);
    check("clean_we_idle", 32'(r1_we), 32'd0);

    // Stuck-at-1 bit 5 at 0x37: caught by the first M1 read of that word.
    f1_addr = 9'h037; f1_s1 = 32'h0000_0020;
    expect_result("sa1_37", 1'b0, 32'h37, 32'h0000_0020, 32'h0000_0000, 368);
    run(1, -1, -1, -1, n, ab);
    score(1, n);

    // Stuck-at-0 bit 31 at 0xFF: survives M1, caught by the M2 ascending read.
    f1_addr = 9'h0FF; f1_s1 = 32'h0; f1_s0 = 32'h8000_0000;
    expect_result("sa0_ff", 1'b0, 32'hFF, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1280);
    run(1, -1, -1, -1, n, ab);
    score(1, n);
    f1_s0 = 32'h0;

    // COLS=2: fault appears once M5 starts; a stray start while busy must be ignored.
    f2_addr = 9'h100; f2_s1 = 32'h0;
    expect_result("c2_m5", 1'b0, 32'h100, 32'h0000_0001, 32'h0000_0000, 4866);
    run(2, 4609, 100, -1, n, ab);
    score(2, n);
    f2_s1 = 32'h0;

    // Reset mid-test, then a complete clean run.
    run(1, -1, -1, 1000, n, ab);
    check("rst_aborted", 32'(ab), 32'd1);
    check_reset_vals("midrst");
    expect_result("after_rst", 1'b1, 32'h0, 32'h0, 32'h0, FullBusy);
    run(1, -1, -1, -1, n, ab);
    score(1, n);

`ifdef BIST_CHECKERBOARD_EN
    // Bits 1:0 shorted at 0x10: invisible to solid backgrounds, caught in pass two.
    f1_addr = 9'h010; f1_sh = 1'b1;
    expect_result("short_10", 1'b0, 32'h10, 32'h5555_5554, 32'h5555_5555, 2851);
    run(1, -1, -1, -1, n, ab);
    score(1, n);
    f1_sh = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
